// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// access_ok() is the single definition of a legal, aligned access.
package mem_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULTSRC_MEM = 2'b01;

   // Stores only come in signed-size flavours; unsigned encodings are load-only.
   function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
      logic legal;
      logic mis;
      if (we) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                      (f3 == F3_BU) || (f3 == F3_HU);
      mis = (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
            ((f3 == F3_W) && (off != 2'b00));
      return legal && !mis;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus: valid/ready request channel, valid-only response channel.
interface mem_stage_lsu_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_we;
   logic [ADDRESS_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0]    req_wdata;
   logic [3:0]               req_wstrb;
   logic                     rsp_valid;
   logic [DATA_WIDTH-1:0]    rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store lane replication/strobes and load extract/extend.
// Purely combinational so the cache can reuse it unchanged.
module lsu_align
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  we_i,
   input  logic [2:0]            funct3_i,
   input  logic [1:0]            off_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic [DATA_WIDTH-1:0] lane_wdata_o,
   output logic [3:0]            wstrb_o,
   output logic [DATA_WIDTH-1:0] load_o
);

   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      lane_wdata_o = wdata_i;
      wstrb_o      = 4'b1111;
      case (funct3_i[1:0])
         2'b00: begin
            lane_wdata_o = {4{wdata_i[7:0]}};
            wstrb_o      = 4'b0001 << off_i;
         end
         2'b01: begin
            lane_wdata_o = {2{wdata_i[15:0]}};
            wstrb_o      = 4'b0011 << off_i;
         end
         default: ;
      endcase
      if (!we_i) wstrb_o = 4'b0000;
   end

   // Word loads are always aligned, so the shifted word doubles as LW data.
   always_comb begin
      shifted = rdata_i >> {off_i, 3'b000};
      case (funct3_i)
         F3_B:    load_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    load_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   load_o = {24'd0, shifted[7:0]};
         F3_HU:   load_o = {16'd0, shifted[15:0]};
         default: load_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: runs one data-memory access per instruction, stalling
// the pipeline until it completes, and flags misaligned/illegal accesses.
module mem_stage_lsu
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] m_aluresult,
   input  logic [DATA_WIDTH-1:0]    m_wdata,
   input  logic [2:0]               m_funct3,
   input  logic                     m_memwrite,
   input  logic [1:0]               m_resultsrc,
   output logic                     stall,
   output logic [DATA_WIDTH-1:0]    load_data,
   output logic                     load_valid,
   output logic                     mem_err,
   mem_stage_lsu_if.master          bus
);

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     we_q, we_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [2:0]               f3_q, f3_d;
   logic [DATA_WIDTH-1:0]    load_data_q, load_data_d;

   logic                     access;
   logic                     stall_c;
   logic                     req_valid_c;
   logic [DATA_WIDTH-1:0]    lane_wdata;
   logic [3:0]               lane_wstrb;
   logic [DATA_WIDTH-1:0]    load_ext;

   assign access = m_memwrite | (m_resultsrc == RESULTSRC_MEM);

   // Request fields come from latched copies so they stay put until the handshake.
   lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .we_i        (we_q),
      .funct3_i    (f3_q),
      .off_i       (addr_q[1:0]),
      .wdata_i     (wdata_q),
      .rdata_i     (bus.rsp_rdata),
      .lane_wdata_o(lane_wdata),
      .wstrb_o     (lane_wstrb),
      .load_o      (load_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         f3_q        <= 3'b000;
         load_data_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         f3_q        <= f3_d;
         load_data_q <= load_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      f3_d        = f3_q;
      load_data_d = load_data_q;
      stall_c     = 1'b0;
      req_valid_c = 1'b0;
      load_valid  = 1'b0;
      mem_err     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               stall_c = 1'b1;
               if (access_ok(m_memwrite, m_funct3, m_aluresult[1:0])) begin
                  state_d = S_REQ;
                  addr_d  = m_aluresult;
                  we_d    = m_memwrite;
                  wdata_d = m_wdata;
                  f3_d    = m_funct3;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_REQ: begin
            stall_c     = 1'b1;
            req_valid_c = 1'b1;
            if (bus.req_ready) state_d = we_q ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            stall_c = 1'b1;
            if (bus.rsp_valid) begin
               load_data_d = load_ext;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            load_valid = !we_q;
            state_d    = S_IDLE;
         end
         S_ERR: begin
            mem_err = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // IDLE stalls combinationally off the inputs, so mask it while reset is held.
   assign stall         = stall_c & ~rst;
   assign load_data     = load_data_q;
   assign bus.req_valid = req_valid_c;
   assign bus.req_we    = we_q;
   assign bus.req_addr  = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
   assign bus.req_wdata = lane_wdata;
   assign bus.req_wstrb = lane_wstrb;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus random accesses against a
// behavioural model of access legality, lane steering and load extension.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m_aluresult;
   logic [31:0] m_wdata;
   logic [2:0]  m_funct3;
   logic        m_memwrite;
   logic [1:0]  m_resultsrc;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        mem_err;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_ld = 32'h0;

   mem_stage_lsu_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

   mem_stage_lsu #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .m_aluresult(m_aluresult),
      .m_wdata    (m_wdata),
      .m_funct3   (m_funct3),
      .m_memwrite (m_memwrite),
      .m_resultsrc(m_resultsrc),
      .stall      (stall),
      .load_data  (load_data),
      .load_valid (load_valid),
      .mem_err    (mem_err),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          stall_cyc;
      int          err_cnt;
      int          lv_cnt;
      int          req_cnt;
      bit          stable;
      bit          timeout;
      bit          extra;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] ld;
   } obs_t;

   typedef struct {
      bit          err;
      int          stall_cyc;
      int          req_cnt;
      int          lv_cnt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] ld;
   } exp_t;

   // Reference: access size in bytes, alignment by modulo, lanes by multiplication.
   function automatic exp_t model(input bit we, input bit ld, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int rdy, input int rsp,
                                  input logic [31:0] prev_ld);
      exp_t e;
      int   size;
      int   off;
      bit   legal;
      logic [31:0] v;
      off  = int'(addr % 4);
      size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      if (we)      legal = (f3 <= 2);
      else if (ld) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      else         legal = 1'b0;
      e.err    = !legal || (addr % size != 0);
      e.addr   = addr - 32'(off);
      e.wdata  = wdata;
      e.wstrb  = 4'b0000;
      e.ld     = prev_ld;
      e.lv_cnt = 0;
      if (we) begin
         if (size == 1) begin
            e.wdata = (wdata & 32'hFF) * 32'h0101_0101;
            e.wstrb = 4'(1 << off);
         end else if (size == 2) begin
            e.wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
            e.wstrb = 4'(3 << off);
         end else begin
            e.wstrb = 4'b1111;
         end
      end else if (!e.err) begin
         v = rdata >> (8 * off);
         if (size == 1) begin
            v = v & 32'hFF;
            if (f3 == 0 && v >= 128) v = v - 256;
         end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 1 && v >= 32768) v = v - 65536;
         end
         e.ld     = v;
         e.lv_cnt = 1;
      end
      e.req_cnt   = e.err ? 0 : rdy + 1;
      e.stall_cyc = e.err ? 1 : we ? 2 + rdy : 3 + rdy + rsp;
      return e;
   endfunction

   // Presents one instruction in M and plays the memory side until stall drops.
   task automatic drive_access(input bit we, input bit ld, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int rdy, input int rsp,
                               output obs_t o);
      int req_n  = 0;
      int wait_n = 0;
      int cyc    = 0;
      bit hs     = 0;
      bit got    = 0;
      o = '{default: 0};
      o.stable    = 1'b1;
      m_memwrite  = we;
      m_resultsrc = ld ? 2'b01 : 2'b00;
      m_funct3    = f3;
      m_aluresult = addr;
      m_wdata     = wdata;
      while (1) begin
         if (cyc == 200) begin
            o.timeout = 1'b1;
            break;
         end
         cyc++;
         #1;
         if (stall)      o.stall_cyc++;
         if (mem_err)    o.err_cnt++;
         if (load_valid) o.lv_cnt++;
         if (hs && !got && !we) begin
            bus.rsp_valid = (wait_n == rsp);
            bus.rsp_rdata = (wait_n == rsp) ? rdata : $urandom;
            if (wait_n == rsp) got = 1'b1;
            wait_n++;
         end else begin
            bus.rsp_valid = 1'($urandom_range(0, 1));
            bus.rsp_rdata = $urandom;
         end
         if (bus.req_valid) begin
            if (req_n == 0) begin
               o.we    = bus.req_we;
               o.addr  = bus.req_addr;
               o.wdata = bus.req_wdata;
               o.wstrb = bus.req_wstrb;
            end else if (o.we !== bus.req_we || o.addr !== bus.req_addr ||
                         o.wdata !== bus.req_wdata || o.wstrb !== bus.req_wstrb) begin
               o.stable = 1'b0;
            end
            bus.req_ready = (req_n >= rdy);
            req_n++;
         end else begin
            bus.req_ready = 1'b0;
         end
         if (bus.req_valid && bus.req_ready) hs = 1'b1;
         if (!stall) begin
            o.ld = load_data;
            break;
         end
         @(negedge clk);
      end
      o.req_cnt     = req_n;
      @(negedge clk);
      m_memwrite    = 1'b0;
      m_resultsrc   = 2'b00;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      #1;
      if (load_valid || mem_err || stall || bus.req_valid) o.extra = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      m_memwrite  = 1'b1;
      m_resultsrc = 2'b00;
      m_funct3    = 3'b010;
      m_aluresult = 32'h100;
      m_wdata     = 32'hDEAD_BEEF;
      bus.req_ready = 1'b1;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({stall, load_valid, mem_err, bus.req_valid, bus.req_we} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl got stall=%b lv=%b err=%b rv=%b we=%b want all 0",
                  stall, load_valid, mem_err, bus.req_valid, bus.req_we);
      end
      total++;
      if ({load_data, bus.req_addr, bus.req_wdata, bus.req_wstrb} !== 100'b0) begin
         bad++;
         $display("FAIL reset_data got ld=%h addr=%h wd=%h strb=%b want all 0",
                  load_data, bus.req_addr, bus.req_wdata, bus.req_wstrb);
      end
      @(negedge clk);
      m_memwrite    = 1'b0;
      bus.req_ready = 1'b0;
      rst           = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL idle_stall got=%b want=0", stall);
      end
      @(negedge clk);
   endtask

   task automatic test_store();
      obs_t o;
      exp_t e;
      drive_access(1, 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, o);
      e = model(1, 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, last_ld);
      total++;
      if (o.addr !== 32'h100 || o.wstrb !== 4'b1111 || o.wdata !== 32'hDEAD_BEEF || o.we !== 1'b1) begin
         bad++;
         $display("FAIL sw_fields got addr=%h strb=%b wd=%h we=%b want 100/1111/deadbeef/1",
                  o.addr, o.wstrb, o.wdata, o.we);
      end
      total++;
      if (o.stall_cyc !== e.stall_cyc || o.lv_cnt !== 0 || o.err_cnt !== 0) begin
         bad++;
         $display("FAIL sw_timing got stall=%0d lv=%0d err=%0d want stall=%0d lv=0 err=0",
                  o.stall_cyc, o.lv_cnt, o.err_cnt, e.stall_cyc);
      end
      drive_access(1, 0, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, o);
      e = model(1, 0, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, last_ld);
      total++;
      if (o.addr !== e.addr || o.wstrb !== e.wstrb || o.wdata !== e.wdata) begin
         bad++;
         $display("FAIL sb_fields got addr=%h strb=%b wd=%h want addr=%h strb=%b wd=%h",
                  o.addr, o.wstrb, o.wdata, e.addr, e.wstrb, e.wdata);
      end
   endtask

   task automatic test_load_ext();
      obs_t o;
      drive_access(0, 1, 3'b000, 32'h202, 32'h0, 32'h1280_FF34, 0, 0, o);
      total++;
      if (o.ld !== 32'hFFFF_FF80 || o.lv_cnt !== 1 || o.extra) begin
         bad++;
         $display("FAIL lb_ext got ld=%h lv=%0d extra=%b want ffffff80 lv=1", o.ld, o.lv_cnt, o.extra);
      end
      drive_access(0, 1, 3'b100, 32'h202, 32'h0, 32'h1280_FF34, 0, 0, o);
      total++;
      if (o.ld !== 32'h0000_0080 || o.lv_cnt !== 1) begin
         bad++;
         $display("FAIL lbu_ext got ld=%h lv=%0d want 00000080 lv=1", o.ld, o.lv_cnt);
      end
      total++;
      if (o.wstrb !== 4'b0000 || o.we !== 1'b0 || o.stall_cyc !== 3) begin
         bad++;
         $display("FAIL load_req got strb=%b we=%b stall=%0d want 0000/0/3", o.wstrb, o.we, o.stall_cyc);
      end
      last_ld = o.ld;
   endtask

   task automatic test_stall_timing();
      obs_t o;
      drive_access(0, 1, 3'b001, 32'h002, 32'h0, 32'h8001_0000, 3, 1, o);
      total++;
      if (o.stall_cyc !== 7 || o.req_cnt !== 4) begin
         bad++;
         $display("FAIL lh_wait_timing got stall=%0d reqcyc=%0d want 7/4", o.stall_cyc, o.req_cnt);
      end
      total++;
      if (!o.stable || o.addr !== 32'h0) begin
         bad++;
         $display("FAIL lh_req_stable got stable=%b addr=%h want 1/00000000", o.stable, o.addr);
      end
      total++;
      if (o.ld !== 32'hFFFF_8001 || o.lv_cnt !== 1) begin
         bad++;
         $display("FAIL lh_ext got ld=%h lv=%0d want ffff8001 lv=1", o.ld, o.lv_cnt);
      end
      last_ld = o.ld;
   endtask

   task automatic test_errors();
      obs_t o;
      drive_access(0, 1, 3'b010, 32'h101, 32'h0, 32'h5555_AAAA, 0, 0, o);
      total++;
      if (o.err_cnt !== 1 || o.req_cnt !== 0 || o.lv_cnt !== 0 || o.stall_cyc !== 1 || o.extra) begin
         bad++;
         $display("FAIL lw_misalign got err=%0d req=%0d lv=%0d stall=%0d extra=%b want 1/0/0/1/0",
                  o.err_cnt, o.req_cnt, o.lv_cnt, o.stall_cyc, o.extra);
      end
      drive_access(0, 1, 3'b011, 32'h100, 32'h0, 32'h5555_AAAA, 0, 0, o);
      total++;
      if (o.err_cnt !== 1 || o.req_cnt !== 0 || o.lv_cnt !== 0) begin
         bad++;
         $display("FAIL f3_illegal got err=%0d req=%0d lv=%0d want 1/0/0", o.err_cnt, o.req_cnt, o.lv_cnt);
      end
      drive_access(1, 0, 3'b100, 32'h100, 32'h1, 32'h0, 0, 0, o);
      total++;
      if (o.err_cnt !== 1 || o.req_cnt !== 0) begin
         bad++;
         $display("FAIL sbu_illegal got err=%0d req=%0d want 1/0", o.err_cnt, o.req_cnt);
      end
      total++;
      if (load_data !== last_ld) begin
         bad++;
         $display("FAIL ld_hold got=%h want=%h", load_data, last_ld);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      m_memwrite    = 1'b0;
      m_resultsrc   = 2'b01;
      m_funct3      = 3'b010;
      m_aluresult   = 32'h40;
      bus.req_ready = 1'b1;
      bus.rsp_valid = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (bus.req_valid !== 1'b1) begin
         bad++;
         $display("FAIL mr_req got=%b want=1", bus.req_valid);
      end
      @(negedge clk);
      #1;
      total++;
      if (stall !== 1'b1 || bus.req_valid !== 1'b0) begin
         bad++;
         $display("FAIL mr_wait got stall=%b rv=%b want 1/0", stall, bus.req_valid);
      end
      rst = 1'b1;
      #1;
      total++;
      if (stall !== 1'b0 || bus.req_valid !== 1'b0) begin
         bad++;
         $display("FAIL mr_in_reset got stall=%b rv=%b want 0/0", stall, bus.req_valid);
      end
      @(negedge clk);
      rst           = 1'b0;
      m_resultsrc   = 2'b00;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b1;
      bus.rsp_rdata = 32'h1234_5678;
      repeat (3) begin
         @(negedge clk);
         #1;
         total++;
         if (load_valid !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL mr_rsp_dropped got lv=%b stall=%b want 0/0", load_valid, stall);
         end
      end
      bus.rsp_valid = 1'b0;
      last_ld = 32'h0;
      total++;
      if (load_data !== last_ld) begin
         bad++;
         $display("FAIL mr_ld got=%h want=%h", load_data, last_ld);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      obs_t o;
      exp_t e;
      for (int n = 0; n < 60; n++) begin
         bit          we   = 1'($urandom_range(0, 1));
         bit          ld   = we ? 1'($urandom_range(0, 1)) : 1'b1;
         logic [2:0]  f3   = 3'($urandom_range(0, 7));
         logic [31:0] addr = $urandom;
         logic [31:0] wd   = $urandom;
         logic [31:0] rd   = $urandom;
         int          rdy  = $urandom_range(0, 2);
         int          rsp  = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 0) addr = addr & 32'hFFFF_FFFC;
         if ($urandom_range(0, 1) == 0) f3 = 3'($urandom_range(0, 2));
         e = model(we, ld, f3, addr, wd, rd, rdy, rsp, last_ld);
         drive_access(we, ld, f3, addr, wd, rd, rdy, rsp, o);
         total++;
         if (o.timeout || o.extra || o.err_cnt !== int'(e.err) || o.stall_cyc !== e.stall_cyc) begin
            bad++;
            $display("FAIL rnd_ctrl[%0d] got to=%b extra=%b err=%0d stall=%0d want err=%0d stall=%0d",
                     n, o.timeout, o.extra, o.err_cnt, o.stall_cyc, e.err, e.stall_cyc);
         end
         total++;
         if (o.req_cnt !== e.req_cnt || o.lv_cnt !== e.lv_cnt || o.ld !== e.ld) begin
            bad++;
            $display("FAIL rnd_load[%0d] got req=%0d lv=%0d ld=%h want req=%0d lv=%0d ld=%h",
                     n, o.req_cnt, o.lv_cnt, o.ld, e.req_cnt, e.lv_cnt, e.ld);
         end
         if (!e.err) begin
            total++;
            if (o.addr !== e.addr || o.wstrb !== e.wstrb || o.we !== we || !o.stable ||
                (we && o.wdata !== e.wdata)) begin
               bad++;
               $display("FAIL rnd_req[%0d] got addr=%h strb=%b we=%b wd=%h st=%b want addr=%h strb=%b we=%b wd=%h",
                        n, o.addr, o.wstrb, o.we, o.wdata, o.stable, e.addr, e.wstrb, we, e.wdata);
            end
         end
         last_ld = e.ld;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_store();
      test_load_ext();
      test_stall_timing();
      test_errors();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Consumes the registered memory-stage control and data signals (m_aluresult, m_wdata, m_funct3, m_memwrite, m_resultsrc) and performs the data-memory access over a valid/ready request, valid response bus.
- Stalls the pipeline while an access is in flight.
- Returns sign- or zero-extended load data for writeback.
- Raises a one-cycle error for misaligned or illegal accesses.

Parameters:
- DATA_WIDTH, 32, data path width; the only supported value is 32.
- ADDRESS_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- m_aluresult  in  ADDRESS_WIDTH  byte address of the access.
- m_wdata  in  DATA_WIDTH  unaligned store data; the relevant bytes are in the low bits.
- m_funct3  in  3  access size and signedness.
- m_memwrite  in  1  store request.
- m_resultsrc  in  2  value 2'b01 marks a load.
- stall  out  1  holds the F, D, E and M pipeline registers.
- load_data  out  DATA_WIDTH  extended load result.
- load_valid  out  1  load_data is valid this cycle.
- mem_err  out  1  misaligned access or illegal funct3; one-cycle pulse.
- req_valid  out  1  bus request.
- req_ready  in  1  bus accepts the request.
- req_we  out  1  1 = write.
- req_addr  out  ADDRESS_WIDTH  word-aligned address ({addr[31:2], 2'b00}).
- req_wdata  out  DATA_WIDTH  store data replicated into byte lanes.
- req_wstrb  out  4  byte-lane enables.
- rsp_valid  in  1  read data is present.
- rsp_rdata  in  DATA_WIDTH  read word.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. The following outputs are 0 during reset: req_valid, stall, load_valid, mem_err, load_data, req_we, req_addr, req_wdata, req_wstrb.
- Access definitions:
  - access = m_memwrite | (m_resultsrc==2'b01).
  - Both set at once: the store wins.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states IDLE, REQ, WAIT, DONE, ERR:
  - IDLE, no access: stall=0.
  - IDLE, legal aligned access: stall=1 combinationally; go to REQ. Latch addr, we, lane data, wstrb, funct3 and addr[1:0].
  - IDLE, illegal or misaligned access: stall=1; go to ERR. No bus activity.
  - REQ: req_valid=1 and stall=1. All req_* fields are stable until the handshake. On req_ready: a store goes to DONE, a load goes to WAIT.
  - WAIT: stall=1. On rsp_valid, capture the extended rsp_rdata into load_data; go to DONE. rsp_valid seen in any other state is ignored.
  - DONE: stall=0. load_valid=1 for loads only. Return to IDLE. The pipeline advances at the end of this cycle, so IDLE evaluates the next instruction.
  - ERR: mem_err=1 and stall=0 for one cycle; return to IDLE. load_valid=0.
- Latency with a zero-wait bus:
  - Store: 3 cycles (IDLE, REQ, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT, DONE).
  - Each wait cycle on req_ready or rsp_valid adds one cycle.
- Store lanes:
  - SB: wdata={4{b}}, wstrb = 0001 << addr[1:0].
  - SH: wdata={2{h}}, wstrb = 0011 << addr[1:0].
  - SW: wstrb=1111.
  - Loads: wstrb=0000.
- Load extraction:
  - byte = rdata >> (8*addr[1:0]); half = rdata >> (8*addr[1:0]).
  - LB, LH sign-extend; LBU, LHU zero-extend; LW passes through.
- load_data holds its value until the next load capture.
- Mid-operation reset: the unit returns to IDLE immediately, req_valid drops, and the in-flight response is discarded.

Decomposition:
- Package mem_pkg holds:
  - the FSM state enum;
  - funct3 constants (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101);
  - RESULTSRC_MEM=2'b01.
- One combinational sub-module, lsu_align, contains the store lane/strobe generation and the load extract/extend logic. It is reused by the future cache.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, req_ready=1 -> req_addr=0x100, wstrb=1111, req_wdata=0xDEADBEEF. stall is high for 2 cycles and low in DONE.
- SB addr=0x103, wdata=0x000000A5 -> req_addr=0x100, wstrb=1000, req_wdata=0xA5A5A5A5.
- LB addr=0x202 with rsp_rdata=0x1280FF34 -> load_data=0xFFFFFF80. The same access with LBU -> load_data=0x00000080. load_valid pulses exactly once.
- LH addr=0x002, req_ready held low for 3 cycles, then rsp_valid 2 cycles later with rdata=0x8001_0000 -> req fields are stable throughout, load_data=0xFFFF8001, and stall is high for 3+1+2+1 cycles.
- LW addr=0x101 -> mem_err pulses once, req_valid never asserts. funct3=3'b011 with a load -> same response.
- Load in WAIT, rst asserted for 1 cycle -> req_valid=0 and stall=0 immediately. A subsequent rsp_valid produces no load_valid.
